mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock.
REQ-002 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have MEM_pc  input  32  PC of the instruction in MEM, from the EX/MEM register.
REQ-004 SHALL have MEM_instr  input  32  instruction word in MEM.
REQ-005 SHALL have MEM_alu  input  32  EX result: data address for loads/stores, else the result value.
REQ-006 SHALL have MEM_rt  input  32  store data, already forwarded.
REQ-007 SHALL have MEM_fwd  output  32  combinational forwarding value to EX; equals MEM_alu.
REQ-008 SHALL have WB_data  output  32  registered load data or MEM_alu.
REQ-009 SHALL have WB_instr, WB_pc  output  32 each  registered copies of MEM_instr and MEM_pc.

Function
REQ-010 SHALL contain 3072 x 32-bit data words, indexed by MEM_alu[13:2].
REQ-011 SHALL ignore MEM_alu[1:0] on word accesses; no misalignment exception.
REQ-012 SHALL treat addresses >= 0x3000 as out of range: stores dropped, loads return 0.
REQ-013 SHALL read combinationally and write on the rising clk edge; sw writes MEM_rt to word[MEM_alu[13:2]].
REQ-014 SHALL register WB_data, WB_instr and WB_pc on every rising edge when rst=0. Latency is 1 cycle.
REQ-015 SHALL set WB_data to the read word for lw, and to MEM_alu for every other opcode.
REQ-016 SHALL decode opcodes as follows: lw=100011, sw=101011, and with byte mode also lb=100000, lh=100001, lbu=100100, lhu=100101, sb=101000, sh=101001.
REQ-017 SHALL make a store in cycle N visible to a load of the same word in cycle N+1. A back-to-back sw then lw returns the new value.
REQ-018 SHALL write nothing for instr=0 (bubble/nop); the bubble propagates as WB_instr=0.
REQ-019 SHALL have no stall input; one instruction is accepted per cycle unconditionally.

Reset
REQ-020 SHALL clear WB_data, WB_instr, WB_pc and all 3072 memory words to 0 on the first clk edge with rst=1.
REQ-021 SHALL suppress any store present in the same cycle as rst; reset wins.
REQ-022 SHALL return 0 for every load after reset until a store occurs.

Configuration
REQ-023 SHALL use the macro MEM_BYTE_ACCESS_EN.
REQ-024 With MEM_BYTE_ACCESS_EN defined, SHALL support the following:
- sb writes MEM_rt[7:0] to the byte selected by MEM_alu[1:0], little-endian.
- sh writes MEM_rt[15:0] to the half selected by MEM_alu[1].
- lb/lh sign-extend the selected byte or half.
- lbu/lhu zero-extend the selected byte or half.
- Other bytes of the word are preserved.
REQ-025 Without MEM_BYTE_ACCESS_EN, SHALL treat byte/half opcodes as non-memory: no write, and WB_data=MEM_alu.

Structure
REQ-026 SHALL take opcode/func field ranges and opcode constants from the shared const.v package. New byte/half opcode constants SHALL be added there.
REQ-027 SHALL place the storage array, write-enable/byte-mask logic and read path in one sub-module, dm, with ports clk, rst, we, be[3:0], addr[31:0], wdata[31:0] and rdata[31:0].
REQ-028 SHALL keep the load-extension mux and the WB pipeline register in mem_stage itself.

Verification
REQ-029 Reset: rst=1 for one edge with sw pending to 0x0 -> WB_*=0 and lw 0x0 returns 0.
REQ-030 Store/load back-to-back: sw MEM_alu=0x10, MEM_rt=0xDEADBEEF, then lw 0x10 next cycle -> WB_data=0xDEADBEEF one cycle later.
REQ-031 Pass-through: ori with MEM_alu=0x1234, MEM_pc=0x3008 -> WB_data=0x1234 and WB_pc=0x3008 after 1 edge; MEM_fwd=0x1234 combinationally.
REQ-032 Out of range: sw to 0x3000 with 0x55 -> no word changes; lw 0x3000 -> 0.
REQ-033 Byte mode (MEM_BYTE_ACCESS_EN): word 0x20=0x11223344, sb 0x21 with MEM_rt=0x000000AB -> word=0x1122AB44; lb 0x21 -> 0xFFFFFFAB; lbu 0x21 -> 0x000000AB; lh 0x22 -> 0x00001122.
REQ-034 Without the macro: sb to 0x20 -> word unchanged; WB_data equals MEM_alu.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared opcode field ranges, opcode constants and memory-access decode for the MEM stage.
// Byte/half opcodes only decode as memory accesses when MEM_BYTE_ACCESS_EN is defined.
package mem_stage_pkg;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  localparam int          DM_WORDS = 3072;
  localparam logic [31:0] DM_LIMIT = 32'h0000_3000;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  typedef struct packed {
    logic      load;
    logic      store;
    logic      sext;
    acc_size_e size;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [5:0] op);
    mem_op_t d;
    d = '{load: 1'b0, store: 1'b0, sext: 1'b0, size: SZ_WORD};
    case (op)
      OP_LW: d.load  = 1'b1;
      OP_SW: d.store = 1'b1;
`ifdef MEM_BYTE_ACCESS_EN
      OP_LB:  d = '{load: 1'b1, store: 1'b0, sext: 1'b1, size: SZ_BYTE};
      OP_LH:  d = '{load: 1'b1, store: 1'b0, sext: 1'b1, size: SZ_HALF};
      OP_LBU: d = '{load: 1'b1, store: 1'b0, sext: 1'b0, size: SZ_BYTE};
      OP_LHU: d = '{load: 1'b1, store: 1'b0, sext: 1'b0, size: SZ_HALF};
      OP_SB:  d = '{load: 1'b0, store: 1'b1, sext: 1'b0, size: SZ_BYTE};
      OP_SH:  d = '{load: 1'b0, store: 1'b1, sext: 1'b0, size: SZ_HALF};
`endif
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_stage_dm.sv
// Data memory: 3072 x 32-bit words with per-byte write enables, combinational read.
// Addresses at or above DM_LIMIT are out of range: writes dropped, reads return 0.
module dm
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] r_mem [DM_WORDS];
  logic        w_in_range;
  logic [11:0] w_idx;

  assign w_in_range = (addr < DM_LIMIT);
  assign w_idx      = addr[13:2];

  // NOTE: the array is cleared by reset, so it maps to flops rather than a RAM macro;
  // reset has priority so a store coinciding with rst is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DM_WORDS; i++) r_mem[i] <= '0;
    end else if (we && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = w_in_range ? r_mem[w_idx] : '0;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data memory, extends load data, registers the WB bundle.
// Optional byte/half accesses are enabled by defining MEM_BYTE_ACCESS_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_pc,
  input  logic [31:0] MEM_instr,
  input  logic [31:0] MEM_alu,
  input  logic [31:0] MEM_rt,
  output logic [31:0] MEM_fwd,
  output logic [31:0] WB_data,
  output logic [31:0] WB_instr,
  output logic [31:0] WB_pc
);

  mem_op_t     w_dec;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;

  assign w_dec   = decode_op(MEM_instr[OP_HI:OP_LO]);
  assign MEM_fwd = MEM_alu;

  // Store data is replicated across lanes so the byte mask alone selects the target.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_be    = 4'b0000;
    w_wdata = MEM_rt;
    case (w_dec.size)
      SZ_WORD: w_be = 4'b1111;
      SZ_HALF: begin
        w_be    = MEM_alu[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{MEM_rt[15:0]}};
      end
      SZ_BYTE: begin
        w_be    = 4'b0001 << MEM_alu[1:0];
        w_wdata = {4{MEM_rt[7:0]}};
      end
      default: ;
    endcase
  end

  dm u_dm (
    .clk   (clk),
    .rst   (rst),
    .we    (w_dec.store),
    .be    (w_be),
    .addr  (MEM_alu),
    .wdata (w_wdata),
    .rdata (w_rdata)
  );

  assign w_shifted = w_rdata >> {MEM_alu[1:0], 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = MEM_alu[1] ? w_rdata[31:16] : w_rdata[15:0];

  always_comb begin
    w_load_val = w_rdata;
    case (w_dec.size)
      SZ_BYTE: w_load_val = w_dec.sext ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
      SZ_HALF: w_load_val = w_dec.sext ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
      default: ;
    endcase
  end

  // NOTE: pipeline state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_data  <= '0;
      WB_instr <= '0;
      WB_pc    <= '0;
    end else begin
      WB_data  <= w_dec.load ? w_load_val : MEM_alu;
      WB_instr <= MEM_instr;
      WB_pc    <= MEM_pc;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-addressed reference memory, directed cases, random traffic.
// Checks adapt to MEM_BYTE_ACCESS_EN when it is defined for the build.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] MEM_pc, MEM_instr, MEM_alu, MEM_rt;
  logic [31:0] MEM_fwd, WB_data, WB_instr, WB_pc;

  int checks   = 0;
  int failures = 0;

`ifdef MEM_BYTE_ACCESS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, LB = 6'b100000, LH = 6'b100001;
  localparam logic [5:0] LBU = 6'b100100, LHU = 6'b100101, SB = 6'b101000, SH = 6'b101001;
  localparam logic [5:0] ORI = 6'b001101, ADDI = 6'b001000, RTYPE = 6'b000000;
  localparam int unsigned LIMIT = 32'h3000;

  // Reference model: byte-addressed little-endian memory plus expected WB values.
  logic [7:0]  m_bytes [12288];
  logic [31:0] exp_data, exp_instr, exp_pc;
  bit          exp_valid = 1'b0;

  mem_stage dut (
    .clk       (clk),
    .rst       (rst),
    .MEM_pc    (MEM_pc),
    .MEM_instr (MEM_instr),
    .MEM_alu   (MEM_alu),
    .MEM_rt    (MEM_rt),
    .MEM_fwd   (MEM_fwd),
    .WB_data   (WB_data),
    .WB_instr  (WB_instr),
    .WB_pc     (WB_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (a < LIMIT) return m_bytes[int'(a)];
    return 8'h00;
  endfunction

  task automatic wr_byte(input logic [31:0] a, input logic [7:0] v);
    if (a < LIMIT) m_bytes[int'(a)] = v;
  endtask

  task automatic model_edge(input logic r, input logic [31:0] instr, pc, alu, rt);
    logic [5:0]  op;
    logic [31:0] w, h, b;
    op = instr[31:26];
    exp_valid = 1'b1;
    if (r) begin
      for (int i = 0; i < 12288; i++) m_bytes[i] = 8'h00;
      exp_data = '0; exp_instr = '0; exp_pc = '0;
      return;
    end
    w = alu & ~32'd3;
    h = alu & ~32'd1;
    exp_instr = instr;
    exp_pc    = pc;
    exp_data  = alu;
    if (op == LW)
      exp_data = {rd_byte(w + 3), rd_byte(w + 2), rd_byte(w + 1), rd_byte(w)};
    else if (op == SW)
      for (int k = 0; k < 4; k++) wr_byte(w + k, rt[8*k +: 8]);
    else if (BYTE_EN) begin
      b = {24'b0, rd_byte(alu)};
      case (op)
        LB:  exp_data = b[7] ? (b | 32'hFFFF_FF00) : b;
        LBU: exp_data = b;
        LH:  exp_data = $signed({rd_byte(h + 1), rd_byte(h)});
        LHU: exp_data = {16'b0, rd_byte(h + 1), rd_byte(h)};
        SB:  wr_byte(alu, rt[7:0]);
        SH:  begin wr_byte(h, rt[7:0]); wr_byte(h + 1, rt[15:8]); end
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input logic r, input logic [31:0] instr, pc, alu, rt);
    rst = r; MEM_instr = instr; MEM_pc = pc; MEM_alu = alu; MEM_rt = rt;
    @(posedge clk);
    model_edge(r, instr, pc, alu, rt);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 26'(($urandom() | 32'h1) & 32'h03FF_FFFF)};
  endfunction

  // Compare process: WB bundle against the model and MEM_fwd against the driven MEM_alu.
  always @(negedge clk) begin
    check("fwd", MEM_fwd, MEM_alu);
    if (exp_valid) begin
      check("wb_data", WB_data, exp_data);
      check("wb_instr", WB_instr, exp_instr);
      check("wb_pc", WB_pc, exp_pc);
    end
  end

  initial begin
    logic [5:0]  ops [12];
    logic [31:0] instr, alu;
    int          sel;
    ops = '{LW, SW, LB, LH, LBU, LHU, SB, SH, ORI, ADDI, RTYPE, RTYPE};

    // Reset with a store to 0x0 pending, then a load of 0x0.
    cycle(1'b1, mk(SW), 32'h100, 32'h0, 32'h1234_5678);
    check("rst_wb_data", WB_data, 32'h0);
    check("rst_wb_instr", WB_instr, 32'h0);
    check("rst_wb_pc", WB_pc, 32'h0);
    cycle(1'b0, mk(LW), 32'h104, 32'h0, 32'h0);
    check("rst_lw0", WB_data, 32'h0);

    // Back-to-back store then load.
    cycle(1'b0, mk(SW), 32'h108, 32'h10, 32'hDEAD_BEEF);
    cycle(1'b0, mk(LW), 32'h10C, 32'h10, 32'h0);
    check("b2b_lw", WB_data, 32'hDEAD_BEEF);

    // Pass-through of a non-memory op.
    rst = 1'b0; MEM_instr = mk(ORI); MEM_alu = 32'h1234; MEM_pc = 32'h3008; MEM_rt = '0;
    #1 check("ori_fwd", MEM_fwd, 32'h1234);
    cycle(1'b0, MEM_instr, 32'h3008, 32'h1234, 32'h0);
    check("ori_data", WB_data, 32'h1234);
    check("ori_pc", WB_pc, 32'h3008);

    // Out-of-range store and load.
    cycle(1'b0, mk(SW), 32'h110, 32'h3000, 32'h55);
    cycle(1'b0, mk(LW), 32'h114, 32'h3000, 32'h0);
    check("oor_lw", WB_data, 32'h0);
    cycle(1'b0, mk(LW), 32'h118, 32'h10, 32'h0);
    check("oor_keep", WB_data, 32'hDEAD_BEEF);

    // Sub-word store into a known word.
    cycle(1'b0, mk(SW), 32'h11C, 32'h20, 32'h1122_3344);
    cycle(1'b0, mk(SB), 32'h120, 32'h21, 32'h0000_00AB);
    cycle(1'b0, mk(LW), 32'h124, 32'h20, 32'h0);
    if (BYTE_EN) begin
      check("sb_word", WB_data, 32'h1122_AB44);
      cycle(1'b0, mk(LB), 32'h128, 32'h21, 32'h0);
      check("lb", WB_data, 32'hFFFF_FFAB);
      cycle(1'b0, mk(LBU), 32'h12C, 32'h21, 32'h0);
      check("lbu", WB_data, 32'h0000_00AB);
      cycle(1'b0, mk(LH), 32'h130, 32'h22, 32'h0);
      check("lh", WB_data, 32'h0000_1122);
    end else begin
      check("sb_ignored", WB_data, 32'h1122_3344);
      cycle(1'b0, mk(SB), 32'h128, 32'h21, 32'h0000_00AB);
      check("sb_alu", WB_data, 32'h21);
    end

    // Random traffic concentrated on a small window and the range boundary.
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 11);
      instr = ($urandom_range(0, 15) == 0) ? 32'h0 : mk(ops[sel]);
      case ($urandom_range(0, 9))
        7:       alu = 32'h2FF0 + $urandom_range(0, 15);
        8:       alu = 32'h3000 + $urandom_range(0, 15);
        9:       alu = $urandom();
        default: alu = $urandom_range(0, 63);
      endcase
      cycle($urandom_range(0, 79) == 0, instr, $urandom(), alu, $urandom());
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
